regfile_wport_arbiter: RTL and testbench

- Shares the single register-file write port (WE/rW/W) between two requesters: the pipeline WB stage and the multi-cycle mul/div unit (MDU).
- Keeps a busy-register scoreboard so decode can stall on operands the MDU has not yet written.
- Sits between the WB stage, the MDU and the register file in the pipelined CPU.

---
 rtl/regfile_wport_arbiter_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_wport_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Optional bypass outputs are enabled with the RF_WPORT_BYPASS_EN macro.
package regfile_wport_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 5;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Register 0 is hard-wired and never written or tracked.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    ST_NORM  = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard: one bit per register, set on MDU issue,
// cleared on MDU result acceptance (set wins), plus the decode hazard compare.
// A pending MDU write on the port can be folded into the hazard via pend_i.
module regfile_scoreboard
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_rw_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_rw_i,
  input  logic              pend_i,
  input  logic [ADDR_W-1:0] pend_rw_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  output logic              hazard_o
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit_a_c;
  logic            hit_b_c;

  // Next busy vector: clear first so a same-cycle set of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_rw_i] = 1'b0;
    end
    if (set_i && (set_rw_i != ZERO_A)) begin
      busy_d[set_rw_i] = 1'b1;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Operand hazard: busy, or its MDU write is still on the port this cycle.
  always_comb begin
    hit_a_c  = (ra_i != ZERO_A) &&
               (busy_q[ra_i] || (pend_i && (pend_rw_i == ra_i)));
    hit_b_c  = (rb_i != ZERO_A) &&
               (busy_q[rb_i] || (pend_i && (pend_rw_i == rb_i)));
    hazard_o = hit_a_c || hit_b_c;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between WB and the MDU,
// with MDU starvation protection (one-entry WB buffer) and a busy scoreboard.
// Define RF_WPORT_BYPASS_EN to add the fwd_a_en/fwd_b_en/fwd_data bypass outputs.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rw,
  input  logic [DATA_W-1:0] wb_w,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rw,
  input  logic [DATA_W-1:0] mdu_w,
  output logic              mdu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  output logic              hazard,
  output logic              stall_o,
  output logic              WE,
  output logic [ADDR_W-1:0] rW,
  output logic [DATA_W-1:0] W
`ifdef RF_WPORT_BYPASS_EN
  ,
  output logic              fwd_a_en,
  output logic              fwd_b_en,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned       CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] buf_rw_q;
  logic [DATA_W-1:0] buf_w_q;
  logic              we_q;
  logic [ADDR_W-1:0] rw_q;
  logic [DATA_W-1:0] w_q;
  logic              force_c;
  logic              ready_c;
  logic              pend_c;

  // Forced MDU grant after STARVE_LIMIT lost cycles; MDU otherwise only wins an idle WB.
  always_comb begin
    force_c = !rst && (state_q == ST_NORM) && wb_we && mdu_valid && (cnt_q == CNT_LIM);
    ready_c = !rst && (state_q == ST_NORM) && mdu_valid && (!wb_we || force_c);
  end

  assign mdu_ready = ready_c;
  assign stall_o   = force_c;
  assign WE        = we_q;
  assign rW        = rw_q;
  assign W         = w_q;

  // Arbiter FSM with registered write port, starve counter and WB buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORM;
      cnt_q    <= '0;
      buf_rw_q <= '0;
      buf_w_q  <= '0;
      we_q     <= 1'b0;
      rw_q     <= '0;
      w_q      <= '0;
    end else begin
      case (state_q)
        ST_NORM: begin
          if (force_c) begin
            we_q     <= (mdu_rw != ZERO_A);
            rw_q     <= mdu_rw;
            w_q      <= mdu_w;
            buf_rw_q <= wb_rw;
            buf_w_q  <= wb_w;
            cnt_q    <= '0;
            state_q  <= ST_DRAIN;
          end else if (wb_we) begin
            we_q <= (wb_rw != ZERO_A);
            rw_q <= wb_rw;
            w_q  <= wb_w;
            if (!mdu_valid) begin
              cnt_q <= '0;
            end else if (cnt_q < CNT_LIM) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (mdu_valid) begin
            we_q  <= (mdu_rw != ZERO_A);
            rw_q  <= mdu_rw;
            w_q   <= mdu_w;
            cnt_q <= '0;
          end else begin
            we_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        ST_DRAIN: begin
          we_q    <= (buf_rw_q != ZERO_A);
          rw_q    <= buf_rw_q;
          w_q     <= buf_w_q;
          state_q <= ST_NORM;
        end
        default: state_q <= ST_NORM;
      endcase
    end
  end

`ifdef RF_WPORT_BYPASS_EN
  // Port data is forwarded, so a write on the port no longer blocks decode.
  assign pend_c   = 1'b0;
  assign fwd_a_en = we_q && (rw_q == rA);
  assign fwd_b_en = we_q && (rw_q == rB);
  assign fwd_data = w_q;
`else
  logic wr_mdu_q;

  // Marks that the write now on the port is an MDU result (keeps hazard up one more cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_mdu_q <= 1'b0;
    end else begin
      wr_mdu_q <= ready_c && (mdu_rw != ZERO_A);
    end
  end

  assign pend_c = wr_mdu_q;
`endif

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_i     (issue_valid),
    .set_rw_i  (issue_rd),
    .clr_i     (mdu_valid && ready_c),
    .clr_rw_i  (mdu_rw),
    .pend_i    (pend_c),
    .pend_rw_i (rw_q),
    .ra_i      (rA),
    .rb_i      (rB),
    .hazard_o  (hazard)
  );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_regfile_wport_arbiter;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;
`ifdef RF_WPORT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we, mdu_valid, issue_valid;
  logic [AW-1:0] wb_rw, mdu_rw, issue_rd, rA, rB;
  logic [DW-1:0] wb_w, mdu_w;
  logic          mdu_ready, hazard, stall_o, WE;
  logic [AW-1:0] rW;
  logic [DW-1:0] W;
`ifdef RF_WPORT_BYPASS_EN
  logic          fwd_a_en, fwd_b_en;
  logic [DW-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_w(wb_w),
    .mdu_valid(mdu_valid), .mdu_rw(mdu_rw), .mdu_w(mdu_w), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rA(rA), .rB(rB), .hazard(hazard), .stall_o(stall_o),
    .WE(WE), .rW(rW), .W(W)
`ifdef RF_WPORT_BYPASS_EN
    , .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en), .fwd_data(fwd_data)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rw = '0; wb_w = '0;
    mdu_valid = 0; mdu_rw = '0; mdu_w = '0;
    issue_valid = 0; issue_rd = '0; rA = '0; rB = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    mdu_valid = 1; mdu_rw = 5'd3; rA = 5'd3;
    rst = 1'b1;
    #2;
    checks += 6;
    if (WE !== 1'b0)        begin errors++; $display("FAIL reset_we got=%0h exp=0", WE); end
    if (rW !== '0)          begin errors++; $display("FAIL reset_rw got=%0h exp=0", rW); end
    if (W !== '0)           begin errors++; $display("FAIL reset_w got=%0h exp=0", W); end
    if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_mdu_ready got=%0h exp=0", mdu_ready); end
    if (stall_o !== 1'b0)   begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall_o); end
    if (hazard !== 1'b0)    begin errors++; $display("FAIL reset_hazard got=%0h exp=0", hazard); end
    cyc();
    do_reset();
  endtask

  task automatic test_wb_only();
    do_reset();
    wb_we = 1; wb_rw = 5'd1; wb_w = 32'hffffffff;
    #2;
    checks++;
    if (mdu_ready !== 1'b0) begin errors++; $display("FAIL wbonly_ready got=%0h exp=0", mdu_ready); end
    cyc();
    wb_we = 0;
    checks += 3;
    if (WE !== 1'b1)         begin errors++; $display("FAIL wbonly_we got=%0h exp=1", WE); end
    if (rW !== 5'd1)         begin errors++; $display("FAIL wbonly_rw got=%0h exp=1", rW); end
    if (W !== 32'hffffffff)  begin errors++; $display("FAIL wbonly_w got=%0h exp=ffffffff", W); end
    cyc();
    checks++;
    if (WE !== 1'b0) begin errors++; $display("FAIL wbonly_idle_we got=%0h exp=0", WE); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    wb_we = 1; wb_rw = 5'd0; wb_w = 32'h88888888;
    cyc();
    wb_we = 0;
    checks++;
    if (WE !== 1'b0) begin errors++; $display("FAIL r0_wb_we got=%0h exp=0", WE); end
    issue_valid = 1; issue_rd = 5'd0; rA = 5'd0; rB = 5'd0;
    cyc();
    issue_valid = 0;
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL r0_hazard got=%0h exp=0", hazard); end
    mdu_valid = 1; mdu_rw = 5'd0; mdu_w = 32'h12345678;
    #1;
    checks++;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL r0_mdu_ready got=%0h exp=1", mdu_ready); end
    cyc();
    mdu_valid = 0;
    checks += 2;
    if (WE !== 1'b0)     begin errors++; $display("FAIL r0_mdu_we got=%0h exp=0", WE); end
    if (hazard !== 1'b0) begin errors++; $display("FAIL r0_hazard2 got=%0h exp=0", hazard); end
  endtask

  task automatic test_starvation();
    do_reset();
    wb_we = 1; wb_rw = 5'd2; wb_w = 32'h22220002;
    mdu_valid = 1; mdu_rw = 5'd5; mdu_w = 32'hdeadbeef;
    for (int i = 0; i < int'(LIM); i++) begin
      #2;
      checks += 2;
      if (mdu_ready !== 1'b0) begin errors++; $display("FAIL starve_wait_ready[%0d] got=%0h exp=0", i, mdu_ready); end
      if (stall_o !== 1'b0)   begin errors++; $display("FAIL starve_wait_stall[%0d] got=%0h exp=0", i, stall_o); end
      cyc();
      checks++;
      if (WE !== 1'b1 || rW !== 5'd2) begin errors++; $display("FAIL starve_wb_write[%0d] got=%0h/%0h exp=1/2", i, WE, rW); end
    end
    #2;
    checks += 2;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL starve_force_ready got=%0h exp=1", mdu_ready); end
    if (stall_o !== 1'b1)   begin errors++; $display("FAIL starve_force_stall got=%0h exp=1", stall_o); end
    cyc();
    // DRAIN: WB repeats, a fresh MDU result must not be accepted
    mdu_valid = 1; mdu_rw = 5'd6; mdu_w = 32'h66666666;
    checks += 3;
    if (WE !== 1'b1)        begin errors++; $display("FAIL starve_mdu_we got=%0h exp=1", WE); end
    if (rW !== 5'd5)        begin errors++; $display("FAIL starve_mdu_rw got=%0h exp=5", rW); end
    if (W !== 32'hdeadbeef) begin errors++; $display("FAIL starve_mdu_w got=%0h exp=deadbeef", W); end
    #2;
    checks += 2;
    if (stall_o !== 1'b0)   begin errors++; $display("FAIL drain_stall got=%0h exp=0", stall_o); end
    if (mdu_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%0h exp=0", mdu_ready); end
    cyc();
    checks += 2;
    if (WE !== 1'b1 || rW !== 5'd2) begin errors++; $display("FAIL drain_buf_write got=%0h/%0h exp=1/2", WE, rW); end
    if (W !== 32'h22220002)         begin errors++; $display("FAIL drain_buf_w got=%0h exp=22220002", W); end
    wb_we = 0;
    #2;
    checks++;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_drain_ready got=%0h exp=1", mdu_ready); end
    cyc();
    mdu_valid = 0;
    checks++;
    if (WE !== 1'b1 || rW !== 5'd6) begin errors++; $display("FAIL post_drain_mdu got=%0h/%0h exp=1/6", WE, rW); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_we = 1; wb_rw = 5'd3; wb_w = 32'h11111111;
    mdu_valid = 1; mdu_rw = 5'd5; mdu_w = 32'h55555555;
    repeat (LIM) cyc();
    #2;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_stall got=%0h exp=1", stall_o); end
    cyc();
    mdu_valid = 0;
    checks++;
    if (WE !== 1'b1 || rW !== 5'd5) begin errors++; $display("FAIL rstmid_drain_port got=%0h/%0h exp=1/5", WE, rW); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b0) begin errors++; $display("FAIL rstmid_we_async got=%0h exp=0", WE); end
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (WE !== 1'b0) begin errors++; $display("FAIL rstmid_no_write[%0d] got=%0h/%0h exp=0", i, WE, rW); end
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_rd = 5'd7; rA = 5'd7; rB = 5'd0;
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_before_set got=%0h exp=0", hazard); end
    cyc();
    issue_valid = 0;
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_busy_a got=%0h exp=1", hazard); end
    rA = 5'd0; rB = 5'd7;
    #1;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_busy_b got=%0h exp=1", hazard); end
    rA = 5'd7; rB = 5'd0;
    cyc();
    mdu_valid = 1; mdu_rw = 5'd7; mdu_w = 32'h00000077;
    #2;
    checks += 2;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL sb_mdu_ready got=%0h exp=1", mdu_ready); end
    if (hazard !== 1'b1)    begin errors++; $display("FAIL sb_handshake_hazard got=%0h exp=1", hazard); end
    cyc();
    mdu_valid = 0;
    checks++;
    if (WE !== 1'b1 || rW !== 5'd7) begin errors++; $display("FAIL sb_write_r7 got=%0h/%0h exp=1/7", WE, rW); end
    #2;
    checks++;
    if (hazard !== !BYP) begin errors++; $display("FAIL sb_port_cycle_hazard got=%0h exp=%0h", hazard, !BYP); end
`ifdef RF_WPORT_BYPASS_EN
    checks += 2;
    if (fwd_a_en !== 1'b1)         begin errors++; $display("FAIL sb_fwd_a got=%0h exp=1", fwd_a_en); end
    if (fwd_data !== 32'h00000077) begin errors++; $display("FAIL sb_fwd_data got=%0h exp=77", fwd_data); end
`endif
    cyc();
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%0h exp=0", hazard); end
    issue_valid = 1; issue_rd = 5'd7;
    cyc();
    mdu_valid = 1; mdu_rw = 5'd7; mdu_w = 32'h0000007b;
    #2;
    checks++;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL sb_same_ready got=%0h exp=1", mdu_ready); end
    cyc();
    issue_valid = 0; mdu_valid = 0;
    cyc();
    cyc();
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0h exp=1", hazard); end
    mdu_valid = 1;
    cyc();
    mdu_valid = 0;
    cyc();
    cyc();
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_final_clear got=%0h exp=0", hazard); end
  endtask

`ifdef RF_WPORT_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    wb_we = 1; wb_rw = 5'd4; wb_w = 32'h00000042; rA = 5'd1; rB = 5'd4;
    cyc();
    wb_we = 0;
    #1;
    checks += 4;
    if (WE !== 1'b1 || rW !== 5'd4) begin errors++; $display("FAIL byp_port got=%0h/%0h exp=1/4", WE, rW); end
    if (fwd_b_en !== 1'b1)          begin errors++; $display("FAIL byp_fwd_b got=%0h exp=1", fwd_b_en); end
    if (fwd_a_en !== 1'b0)          begin errors++; $display("FAIL byp_fwd_a got=%0h exp=0", fwd_a_en); end
    if (fwd_data !== 32'h00000042)  begin errors++; $display("FAIL byp_fwd_data got=%0h exp=42", fwd_data); end
  endtask
`endif

  // Random traffic against a model of the arbitration and scoreboard rules.
  task automatic test_random(input int n);
    int            m_wait;
    bit            m_drain, m_we, m_src_mdu, prev_stall, prev_ready;
    bit            m_busy [32];
    logic [AW-1:0] m_rw, m_buf_rw;
    logic [DW-1:0] m_w, m_buf_w;
    bit            e_ready, e_stall, e_haz, pa, pb;
    do_reset();
    m_wait = 0; m_drain = 0; m_we = 0; m_src_mdu = 0; prev_stall = 0; prev_ready = 0;
    m_rw = '0; m_w = '0; m_buf_rw = '0; m_buf_w = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    for (int c = 0; c < n; c++) begin
      // Pipeline frozen by a stall repeats its WB request; MDU holds until accepted.
      if (!prev_stall) begin
        wb_we = ($urandom_range(0, 9) < 7);
        wb_rw = AW'($urandom_range(0, 7));
        wb_w  = $urandom;
      end
      if (!mdu_valid || prev_ready) begin
        mdu_valid = ($urandom_range(0, 9) < 5);
        mdu_rw    = AW'($urandom_range(0, 7));
        mdu_w     = $urandom;
      end
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = AW'($urandom_range(0, 7));
      rA          = AW'($urandom_range(0, 7));
      rB          = AW'($urandom_range(0, 7));

      e_stall = !m_drain && wb_we && mdu_valid && (m_wait >= int'(LIM));
      e_ready = !m_drain && mdu_valid && (!wb_we || e_stall);
      pa      = !BYP && m_we && m_src_mdu && (m_rw == rA);
      pb      = !BYP && m_we && m_src_mdu && (m_rw == rB);
      e_haz   = (rA != 0 && (m_busy[rA] || pa)) || (rB != 0 && (m_busy[rB] || pb));

      #2;
      checks += 4;
      if (mdu_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, mdu_ready, e_ready); end
      if (stall_o !== e_stall)   begin errors++; $display("FAIL rnd_stall c=%0d got=%0h exp=%0h", c, stall_o, e_stall); end
      if (hazard !== e_haz)      begin errors++; $display("FAIL rnd_hazard c=%0d got=%0h exp=%0h", c, hazard, e_haz); end
      if (WE !== m_we)           begin errors++; $display("FAIL rnd_we c=%0d got=%0h exp=%0h", c, WE, m_we); end
      if (m_we) begin
        checks += 2;
        if (rW !== m_rw) begin errors++; $display("FAIL rnd_rw c=%0d got=%0h exp=%0h", c, rW, m_rw); end
        if (W !== m_w)   begin errors++; $display("FAIL rnd_w c=%0d got=%0h exp=%0h", c, W, m_w); end
      end
`ifdef RF_WPORT_BYPASS_EN
      checks += 2;
      if (fwd_a_en !== (m_we && m_rw == rA)) begin errors++; $display("FAIL rnd_fwd_a c=%0d got=%0h", c, fwd_a_en); end
      if (fwd_b_en !== (m_we && m_rw == rB)) begin errors++; $display("FAIL rnd_fwd_b c=%0d got=%0h", c, fwd_b_en); end
`endif

      // Who owns the port next cycle.
      if (m_drain) begin
        m_we = (m_buf_rw != 0); m_rw = m_buf_rw; m_w = m_buf_w; m_src_mdu = 0;
        m_drain = 0;
      end else if (e_stall) begin
        m_we = (mdu_rw != 0); m_rw = mdu_rw; m_w = mdu_w; m_src_mdu = 1;
        m_buf_rw = wb_rw; m_buf_w = wb_w; m_drain = 1; m_wait = 0;
      end else if (wb_we) begin
        m_we = (wb_rw != 0); m_rw = wb_rw; m_w = wb_w; m_src_mdu = 0;
        m_wait = mdu_valid ? ((m_wait < int'(LIM)) ? m_wait + 1 : m_wait) : 0;
      end else if (mdu_valid) begin
        m_we = (mdu_rw != 0); m_rw = mdu_rw; m_w = mdu_w; m_src_mdu = 1; m_wait = 0;
      end else begin
        m_we = 0; m_src_mdu = 0; m_wait = 0;
      end
      if (mdu_valid && e_ready) m_busy[mdu_rw] = 0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;

      prev_stall = e_stall;
      prev_ready = e_ready;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #3;
    test_reset();
    test_wb_only();
    test_reg_zero();
    test_starvation();
    test_reset_mid();
    test_scoreboard();
`ifdef RF_WPORT_BYPASS_EN
    test_bypass();
`endif
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
